// File: rtl/ps2_scan_rx_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Holds the frame FSM states, the prefix scan codes and the key-word layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_word_t;

    localparam int unsigned KEY_W = $bits(key_word_t);

    // Odd parity: ones over data plus parity bit must be odd.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Key-word output bus of the PS/2 receiver: valid/ready handshake plus occupancy.
interface ps2_scan_rx_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          out_ready;
    logic          out_valid;
    logic [7:0]    out_code;
    logic          out_ext;
    logic          out_release;
    logic [CW-1:0] fifo_count;

    modport master (
        input  out_ready,
        output out_valid, out_code, out_ext, out_release, fifo_count
    );

    modport slave (
        output out_ready,
        input  out_valid, out_code, out_ext, out_release, fifo_count
    );
endinterface

// File: rtl/ps2_scan_rx_sync_fifo.sv
// Registered synchronous FIFO with occupancy count and overflow pulse.
// Head word is visible one cycle after the push (no fall-through).
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             r_ovf;

    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic [CW-1:0]    w_count_nx;

    // A pop frees a slot in the same cycle, so push-while-full is legal then.
    always_comb begin
        w_full     = (r_count == CW'(DEPTH));
        w_pop      = i_pop && r_valid;
        w_wr       = i_push && (!w_full || w_pop);
        w_count_nx = r_count + CW'(w_wr) - CW'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nx;
            r_valid <= (w_count_nx != '0);
            r_ovf   <= i_push && w_full && !w_pop;
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = r_valid;
    assign o_count    = r_count;
    assign o_overflow = r_ovf;
endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise and filter the device clock, deframe 11-bit
// frames, fold E0/F0 prefixes into key words and queue them in a FIFO.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_scan_rx_if.master kb,
    output logic          frame_err,
    output logic          overflow
);
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]     r_clk_sync;
    logic [1:0]     r_dat_sync;
    logic           r_filt;
    logic [FCW-1:0] r_flt_cnt;
    logic           r_sample;

    ps2_state_e     r_state,  w_state_nx;
    logic [7:0]     r_shift,  w_shift_nx;
    logic [2:0]     r_bit,    w_bit_nx;
    logic           r_par,    w_par_nx;
    logic [TOW-1:0] r_to,     w_to_nx;
    logic           r_acc,    w_acc_nx;
    logic           w_err_nx;
    logic           w_data;

    logic           r_ext_pend;
    logic           r_rel_pend;
    logic           w_push;
    key_word_t      w_word;
    key_word_t      w_head;
    logic           w_valid;
    logic [CW-1:0]  w_count;
    logic           w_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // Filtered level flips after FILTER_LEN consecutive differing samples; 1->0 strobes r_sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt    <= 1'b1;
            r_flt_cnt <= '0;
            r_sample  <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            if (r_clk_sync[1] == r_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_filt    <= r_clk_sync[1];
                r_flt_cnt <= '0;
                r_sample  <= r_filt;
            end else begin
                r_flt_cnt <= r_flt_cnt + FCW'(1);
            end
        end
    end

    assign w_data = r_dat_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit     <= '0;
            r_par     <= 1'b0;
            r_to      <= '0;
            r_acc     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_bit     <= w_bit_nx;
            r_par     <= w_par_nx;
            r_to      <= w_to_nx;
            r_acc     <= w_acc_nx;
            frame_err <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit;
        w_par_nx   = r_par;
        w_to_nx    = r_to;
        w_acc_nx   = 1'b0;
        w_err_nx   = 1'b0;

        // Inter-edge watchdog: only armed while a frame is in progress.
        if (r_sample) begin
            w_to_nx = '0;
        end else if (r_state != ST_IDLE) begin
            if (r_to == TOW'(TIMEOUT_CYCLES - 1)) begin
                w_state_nx = ST_IDLE;
                w_err_nx   = 1'b1;
                w_to_nx    = '0;
            end else begin
                w_to_nx = r_to + TOW'(1);
            end
        end

        if (r_sample) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        w_state_nx = ST_DATA;
                        w_bit_nx   = '0;
                    end
                end
                ST_DATA: begin
                    w_shift_nx = {w_data, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_nx = ST_PARITY;
                    else               w_bit_nx   = r_bit + 3'd1;
                end
                ST_PARITY: begin
                    w_par_nx   = w_data;
                    w_state_nx = ST_STOP;
                end
                ST_STOP: begin
                    if (w_data && odd_parity_ok(r_shift, r_par)) w_acc_nx = 1'b1;
                    else                                          w_err_nx = 1'b1;
                    w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // r_shift keeps the accepted byte until the next frame's first data bit.
    always_comb begin
        w_push      = r_acc && (r_shift != SC_EXT) && (r_shift != SC_BREAK);
        w_word.ext  = r_ext_pend;
        w_word.rel  = r_rel_pend;
        w_word.code = r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (w_err_nx) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (r_acc) begin
            if (r_shift == SC_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (r_shift == SC_BREAK) begin
                r_rel_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     (w_word),
        .i_pop      (kb.out_ready),
        .o_data     (w_head),
        .o_valid    (w_valid),
        .o_count    (w_count),
        .o_overflow (w_ovf)
    );

    assign kb.out_valid   = w_valid;
    assign kb.out_code    = w_head.code;
    assign kb.out_ext     = w_head.ext;
    assign kb.out_release = w_head.rel;
    assign kb.fifo_count  = w_count;
    assign overflow       = w_ovf;
endmodule
